// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the wait-stated data memory.
//   size_t  - access size encoding (3 is reserved and behaves as a word)
//   state_t - access FSM states
//   is_aligned() - natural-alignment test for a given size and byte offset
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bytes are always aligned; halves need an even address; words (and the
    // reserved size code) need a 4-byte aligned address.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] a_lo);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~a_lo[0];
            default: ok = (a_lo == 2'b00);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane steering for the data memory.
//   size, a_lo      - access size and byte offset within the word
//   wd              - right-justified store data
//   be, wdata       - byte enables and lane-replicated write word
//   sext, raw       - load extension mode and raw memory word
//   ld_data         - extracted and extended load value
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  a_lo,
    input  logic [31:0] wd,
    input  logic        sext,
    input  logic [31:0] raw,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    // Store path: replicate the datum across all lanes so the byte enables
    // alone select where it lands; no shifter needed.
    always_comb begin
        be    = 4'b1111;
        wdata = wd;
        case (size)
            SZ_BYTE: begin
                be    = 4'b0001 << a_lo;
                wdata = {4{wd[7:0]}};
            end
            SZ_HALF: begin
                be    = a_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{wd[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = wd;
            end
        endcase
    end

    // Load path: bring the addressed lane down to bit 0, then extend.
    assign shifted = raw >> {a_lo, 3'b000};

    always_comb begin
        ld_data = shifted;
        case (size)
            SZ_BYTE: ld_data = {{24{sext & shifted[7]}}, shifted[7:0]};
            SZ_HALF: ld_data = {{16{sext & shifted[15]}}, shifted[15:0]};
            default: ld_data = raw;
        endcase
    end

endmodule

// File: rtl/dmem_waitstate.sv
// dmem_waitstate: MEM-stage data memory with byte/half/word access,
// sign/zero extension, byte-lane writes and WAIT_STATES extra BUSY cycles.
//   clk, reset (async, active-low)
//   req/we/size/sext/a/wd - access request, held stable while stall=1
//   rd    - load result, valid with ack
//   stall - pipeline hold while an access is in flight
//   ack   - one-cycle completion pulse
//   err   - misaligned-access flag, valid with ack
module dmem_waitstate
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_STATES = 2,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        stall,
    output logic        ack,
    output logic        err
);

    localparam int IDXW = $clog2(DEPTH_WORDS);

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [IDXW+1:0]   a_reg;
    logic [31:0]       wd_reg;
    logic [1:0]        size_reg;
    logic              we_reg;
    logic              sext_reg;
    logic              aligned_reg;
    logic [31:0]       rd_reg;
    logic              ack_reg;
    logic              err_reg;

    logic [31:0]       mem [DEPTH_WORDS];
    logic [31:0]       rdata_reg;
    logic [IDXW-1:0]   ridx;
    logic              last_edge;
    logic              wr_en;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic [31:0]       ld_data;
    logic              unused_addr_bits;

    // Address bits above the array are don't-care: the memory wraps.
    assign unused_addr_bits = ^a[31:IDXW+2];

    dmem_lane_align u_lane (
        .size    (size_reg),
        .a_lo    (a_reg[1:0]),
        .wd      (wd_reg),
        .sext    (sext_reg),
        .raw     (rdata_reg),
        .be      (be),
        .wdata   (wdata),
        .ld_data (ld_data)
    );

    assign last_edge = (state_reg == BUSY) && (cnt_reg == '0);
    assign wr_en     = last_edge && aligned_reg && we_reg;

    // Read address follows the live request while idle, so the registered
    // read is already valid from the first BUSY cycle even with no wait states.
    assign ridx = (state_reg == IDLE) ? a[IDXW+1:2] : a_reg[IDXW+1:2];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[a_reg[IDXW+1:2]][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        rdata_reg <= mem[ridx];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            a_reg       <= '0;
            wd_reg      <= '0;
            size_reg    <= 2'b00;
            we_reg      <= 1'b0;
            sext_reg    <= 1'b0;
            aligned_reg <= 1'b0;
            rd_reg      <= '0;
            ack_reg     <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    ack_reg <= 1'b0;
                    err_reg <= 1'b0;
                    if (req) begin
                        a_reg       <= a[IDXW+1:0];
                        wd_reg      <= wd;
                        size_reg    <= size;
                        we_reg      <= we;
                        sext_reg    <= sext;
                        aligned_reg <= is_aligned(size, a[1:0]);
                        cnt_reg     <= CNT_W'(WAIT_STATES);
                        state_reg   <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end else begin
                        state_reg <= DONE;
                        ack_reg   <= 1'b1;
                        if (aligned_reg) begin
                            err_reg <= 1'b0;
                            if (!we_reg) begin
                                rd_reg <= ld_data;
                            end
                        end else begin
                            err_reg <= 1'b1;
                            rd_reg  <= '0;
                        end
                    end
                end
                DONE: begin
                    // Always return to IDLE; a req seen here is for the next access.
                    ack_reg   <= 1'b0;
                    err_reg   <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Gated by reset so the pipeline is released as soon as reset asserts.
    assign stall = reset & ((state_reg == IDLE) ? req : (state_reg == BUSY));
    assign rd    = rd_reg;
    assign ack   = ack_reg;
    assign err   = err_reg;

endmodule

// File: tb/tb_dmem_waitstate.sv
module tb_dmem_waitstate;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic        we_i;
    logic [1:0]  size_i;
    logic        sext_i;
    logic [31:0] a_i, wd_i;
    logic [31:0] rd0, rd1;
    logic        stall0, stall1, ack0, ack1, err0, err1;

    int checks = 0;
    int failures = 0;
    int cyc_now = 0;

    // Byte-addressed reference memories (256 bytes = 64 words each) and the
    // expected value of rd held by each instance.
    logic [7:0]  mb [2][256];
    logic [31:0] rd_exp [2];
    int          ack_t [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_now <= cyc_now + 1;

    dmem_waitstate #(.DEPTH_WORDS(64), .WAIT_STATES(2), .CNT_W(4)) dut0 (
        .clk(clk), .reset(reset), .req(req0), .we(we_i), .size(size_i),
        .sext(sext_i), .a(a_i), .wd(wd_i), .rd(rd0), .stall(stall0),
        .ack(ack0), .err(err0)
    );

    dmem_waitstate #(.DEPTH_WORDS(64), .WAIT_STATES(0), .CNT_W(4)) dut1 (
        .clk(clk), .reset(reset), .req(req1), .we(we_i), .size(size_i),
        .sext(sext_i), .a(a_i), .wd(wd_i), .rd(rd1), .stall(stall1),
        .ack(ack1), .err(err1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one access from posedge+1 of the accepting cycle until posedge+1
    // of the cycle after ack, comparing timing and results with the model.
    task automatic do_access(input int sel, input logic w, input logic [1:0] sz,
                             input logic sx, input logic [31:0] addr, input logic [31:0] data,
                             output logic [31:0] o_rd, output logic o_err);
        int ws, cyc, scnt, n, ba;
        logic al, exp_err, got_ack;
        logic [31:0] val;
        ws = (sel == 0) ? 2 : 0;
        we_i = w; size_i = sz; sext_i = sx; a_i = addr; wd_i = data;
        if (sel == 0) req0 = 1'b1; else req1 = 1'b1;
        cyc = 0; scnt = 0; got_ack = 1'b0;
        while (cyc < 40) begin
            @(negedge clk);
            if ((sel == 0) ? ack0 : ack1) begin
                got_ack = 1'b1;
                break;
            end
            if ((sel == 0) ? stall0 : stall1) scnt++;
            @(posedge clk); #1;
            cyc++;
        end
        check("ack_seen", {31'd0, got_ack}, 32'd1);
        ack_t[sel] = cyc_now;

        // Model: natural alignment on the wrapped byte address, little-endian.
        n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        ba = int'(addr % 256);
        al = ((ba % n) == 0);
        exp_err = ~al;
        if (!al) begin
            rd_exp[sel] = 32'd0;
        end else if (w) begin
            for (int k = 0; k < n; k++) mb[sel][ba + k] = data[8*k +: 8];
        end else begin
            val = 32'd0;
            for (int k = 0; k < n; k++) val[8*k +: 8] = mb[sel][ba + k];
            if (n < 4 && sx && val[8*n-1]) begin
                for (int k = 8*n; k < 32; k++) val[k] = 1'b1;
            end
            rd_exp[sel] = val;
        end

        o_rd  = (sel == 0) ? rd0 : rd1;
        o_err = (sel == 0) ? err0 : err1;
        check("ack_latency", cyc, ws + 2);
        check("stall_cycles", scnt, ws + 2);
        check("stall_at_ack", {31'd0, (sel == 0) ? stall0 : stall1}, 32'd0);
        check("err", {31'd0, o_err}, {31'd0, exp_err});
        check("rd", o_rd, rd_exp[sel]);
        $display("access dut%0d we=%0d size=%0d sext=%0d a=%h wd=%h rd=%h err=%0d lat=%0d",
                 sel, w, sz, sx, addr, data, o_rd, o_err, cyc);

        @(posedge clk); #1;
        if (sel == 0) req0 = 1'b0; else req1 = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        logic        e;
        int          t0, t1, sel;

        reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
        we_i = 1'b0; size_i = 2'd0; sext_i = 1'b0; a_i = '0; wd_i = '0;
        rd_exp[0] = 32'd0; rd_exp[1] = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rd", rd0, 32'd0);
        check("reset_stall", {31'd0, stall0}, 32'd0);
        check("reset_ack", {31'd0, ack0}, 32'd0);
        check("reset_err", {31'd0, err0}, 32'd0);
        check("reset_rd1", rd1, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("idle_stall", {31'd0, stall0}, 32'd0);
        @(posedge clk); #1;

        // Fill both memories so every later load has defined data.
        for (int i = 0; i < 64; i++) do_access(0, 1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, r, e);
        for (int i = 0; i < 64; i++) do_access(1, 1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, r, e);

        // Word store then load
        do_access(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, r, e);
        do_access(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, r, e);
        check("word_load", r, 32'hDEADBEEF);
        check("word_load_err", {31'd0, e}, 32'd0);

        // Byte-lane merge
        do_access(0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, r, e);
        do_access(0, 1'b1, 2'd0, 1'b0, 32'h22, 32'h55AA00AB, r, e);
        do_access(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, r, e);
        check("byte_merge", r, 32'h11AB3344);

        // Sign and zero extension
        do_access(0, 1'b1, 2'd2, 1'b0, 32'h30, 32'h80FF7F01, r, e);
        do_access(0, 1'b0, 2'd0, 1'b1, 32'h31, 32'h0, r, e);
        check("lb_pos", r, 32'h0000007F);
        do_access(0, 1'b0, 2'd0, 1'b1, 32'h33, 32'h0, r, e);
        check("lb_neg", r, 32'hFFFFFF80);
        do_access(0, 1'b0, 2'd1, 1'b0, 32'h32, 32'h0, r, e);
        check("lhu", r, 32'h000080FF);

        // Misaligned access
        do_access(0, 1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFEF00D, r, e);
        do_access(0, 1'b1, 2'd1, 1'b0, 32'h41, 32'h00001234, r, e);
        check("mis_store_err", {31'd0, e}, 32'd1);
        do_access(0, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, r, e);
        check("mis_store_nowrite", r, 32'hCAFEF00D);
        do_access(0, 1'b0, 2'd2, 1'b0, 32'h42, 32'h0, r, e);
        check("mis_load_err", {31'd0, e}, 32'd1);
        check("mis_load_rd", r, 32'd0);

        // Reset mid-store
        do_access(0, 1'b1, 2'd2, 1'b0, 32'h50, 32'h0, r, e);
        do_access(0, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, r, e);
        we_i = 1'b1; size_i = 2'd2; sext_i = 1'b0; a_i = 32'h50; wd_i = 32'hA5A5A5A5;
        req0 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_reset_stall", {31'd0, stall0}, 32'd1);
        reset = 1'b0;
        #1;
        check("rst_mid_stall", {31'd0, stall0}, 32'd0);
        check("rst_mid_ack", {31'd0, ack0}, 32'd0);
        check("rst_mid_err", {31'd0, err0}, 32'd0);
        check("rst_mid_rd", rd0, 32'd0);
        req0 = 1'b0;
        rd_exp[0] = 32'd0; rd_exp[1] = 32'd0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        do_access(0, 1'b0, 2'd2, 1'b0, 32'h50, 32'h0, r, e);
        check("rst_store_discarded", r, 32'h0);

        // No wait states: address wrap and back-to-back timing
        do_access(1, 1'b1, 2'd2, 1'b0, 32'h104, 32'h13579BDF, r, e);
        do_access(1, 1'b0, 2'd2, 1'b0, 32'h004, 32'h0, r, e);
        check("wrap_alias", r, 32'h13579BDF);
        t0 = ack_t[1];
        do_access(1, 1'b0, 2'd2, 1'b0, 32'h008, 32'h0, r, e);
        t1 = ack_t[1];
        check("b2b_period_a", t1 - t0, 3);
        do_access(1, 1'b0, 2'd0, 1'b1, 32'h00D, 32'h0, r, e);
        check("b2b_period_b", ack_t[1] - t1, 3);

        // Randomized accesses against the byte model
        for (int i = 0; i < 200; i++) begin
            sel = int'($urandom % 2);
            do_access(sel, 1'($urandom), 2'($urandom), 1'($urandom),
                      $urandom % 32'h400, $urandom, r, e);
            if ($urandom % 4 == 0) begin
                repeat (1 + $urandom % 3) begin
                    @(negedge clk);
                    check("gap_stall0", {31'd0, stall0}, 32'd0);
                    check("gap_stall1", {31'd0, stall1}, 32'd0);
                    @(posedge clk); #1;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
